mem_arbiter: RTL and testbench

Shares one single-port synchronous instruction/data memory between the instruction-fetch port and the load/store port of the RISC-V core.
- Grants at most one access per cycle.
- Routes each 1-cycle-latency read response back to the requester that issued it.
- Data accesses have priority, with a bounded-starvation rule for fetch.
- Sits between the core's IF/MEM stages and the memory macro that replaces the combinational ROM.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_streak.sv | 32 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Response owner encoding and default bus widths.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // Wide enough for any data width up to 1024 bits; users slice the low bits.
    localparam logic [127:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DRD,
        OWN_DWR
    } owner_t;

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
// Raises force_if once the pending fetch must be let through.
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic grant_d,
    input  logic grant_if,
    output logic force_if
);

    localparam logic [3:0] LIMIT = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_if || !if_req) begin
            streak <= '0;
        end else if (grant_d && (streak != LIMIT)) begin
            streak <= streak + 4'd1;
        end
    end

    assign force_if = if_req && (streak == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and
// load/store, routing each 1-cycle read response back to its requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = DEF_ADDR_W,
    parameter int unsigned DATA_W          = DEF_DATA_W,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_ready,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ready,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic   force_if;
    logic   grant_d;
    logic   grant_if;
    owner_t owner_q;
    owner_t owner_d;

    always_comb begin
        grant_d  = d_req && !force_if;
        grant_if = if_req && !grant_d;
    end

    assign if_ready = grant_if;
    assign d_ready  = grant_d;
    assign mem_en   = grant_if || grant_d;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_be    = BE_ALL[BE_W-1:0];
            mem_addr  = if_addr;
        end
    end

    mem_arb_streak #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .grant_d  (grant_d),
        .grant_if (grant_if),
        .force_if (force_if)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (grant_d) begin
            owner_d = d_we ? OWN_DWR : OWN_DRD;
        end else if (grant_if) begin
            owner_d = OWN_IF;
        end
    end

    // A flushed fetch still returns its data word, only the valid is suppressed.
    always_comb begin
        if_valid = 1'b0;
        if_rdata = '0;
        d_valid  = 1'b0;
        d_rdata  = '0;
        unique case (owner_q)
            OWN_IF: begin
                if_valid = !if_flush;
                if_rdata = mem_rdata;
            end
            OWN_DRD: begin
                d_valid = 1'b1;
                d_rdata = mem_rdata;
            end
            OWN_DWR: begin
                d_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written reset
// sequence, and randomized traffic checked against a behavioural model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_ready;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_ready;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_ready   (d_ready),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro stand-in, driven purely by the DUT's mem_* port.
    logic [31:0] mem [64];
    logic [31:0] mw;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mw = mem[mem_addr[7:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mw[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr[7:2]] <= mw;
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    // Reference model state: what each requester should see, by request fields.
    logic [31:0] shadow [64];
    int          wait_cnt;
    bit          pend_if, pend_d;
    logic [31:0] pend_data;
    bit          exp_gd, exp_gi;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'h0000_0093;
        if (i == 16) return 32'h1111_2222;
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic model_clear();
        wait_cnt  = 0;
        pend_if   = 0;
        pend_d    = 0;
        pend_data = '0;
    endtask

    task automatic model_check();
        exp_gd = d_req && !(if_req && wait_cnt == MAXS);
        exp_gi = if_req && !exp_gd;
        chk("if_ready", if_ready, exp_gi);
        chk("d_ready", d_ready, exp_gd);
        chk("mem_en", mem_en, exp_gd | exp_gi);
        chk("mem_we", mem_we, exp_gd & d_we);
        chk("mem_be", mem_be, exp_gd ? d_be : (exp_gi ? 4'hF : 4'h0));
        chk("mem_addr", mem_addr, exp_gd ? d_addr : (exp_gi ? if_addr : 32'h0));
        if (!exp_gi) chk("mem_wdata", mem_wdata, exp_gd ? d_wdata : 32'h0);
        chk("if_valid", if_valid, pend_if && !if_flush);
        chk("if_rdata", if_rdata, pend_if ? pend_data : 32'h0);
        chk("d_valid", d_valid, pend_d);
        chk("d_rdata", d_rdata, pend_d ? pend_data : 32'h0);
    endtask

    task automatic model_update();
        int idx;
        if (rst) begin
            model_clear();
            return;
        end
        pend_if   = exp_gi;
        pend_d    = exp_gd;
        pend_data = '0;
        if (exp_gd) begin
            idx = int'(d_addr[7:2]);
            if (d_we) begin
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) shadow[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end else begin
                pend_data = shadow[idx];
            end
        end else if (exp_gi) begin
            pend_data = shadow[int'(if_addr[7:2])];
        end
        // Fetch has now been passed over one more time, or is no longer waiting.
        if (if_req && exp_gd) wait_cnt = (wait_cnt < MAXS) ? wait_cnt + 1 : MAXS;
        else wait_cnt = 0;
    endtask

    task automatic half_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd, input logic [3:0] be);
        if_req   = ir;
        if_addr  = ia;
        if_flush = fl;
        d_req    = dr;
        d_we     = dw;
        d_addr   = da;
        d_wdata  = dd;
        d_be     = be;
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [3:0]  be;
        logic        e_ifr;
        logic        e_dr;
        logic        e_we;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dv;
        logic [31:0] e_dd;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic fl, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dd, logic [3:0] be,
                                logic e_ifr, logic e_dr, logic e_we, logic e_ifv,
                                logic [31:0] e_ifd, logic e_dv, logic [31:0] e_dd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.be = be;
        v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_we = e_we; v.e_ifv = e_ifv; v.e_ifd = e_ifd;
        v.e_dv = e_dv; v.e_dd = e_dd;
        return v;
    endfunction

    vec_t vecs[$];
    int   d_before_if;
    bit   seen_if;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        mem_rdata = '0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();

        // Directed vectors: single fetch, load/store pair, contention, flush.
        vecs.push_back(mk(1, 32'h0C, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 32'h93, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h40, 0, 0,            0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h44, 32'hDEADBEEF, 4'hF,
                                                                  0, 1, 1, 0, 0, 1, 32'h11112222));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h44, 0, 0,            0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,            0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,        0, 1, 0, 0, 0, 1, 32'hA5000020));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,            1, 0, 0, 0, 0, 1, 32'hA5000020));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,            0, 1, 0, 1, 32'hA5000000, 0, 0));
        for (int k = 6; k <= 8; k++)
            vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,        0, 1, 0, 0, 0, 1, 32'hA5000020));
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h80, 0, 0,            1, 0, 0, 0, 0, 1, 32'hA5000020));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 32'hA5000000, 0, 0));
        vecs.push_back(mk(1, 32'h0C, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 32'h93, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 32'hA5000000, 0, 0));

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_if_valid", if_valid, 0);
        chk("reset_d_valid", d_valid, 0);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].fl, vecs[i].dr, vecs[i].dw,
                  vecs[i].da, vecs[i].dd, vecs[i].be);
            half_check();
            chk($sformatf("vec%0d_if_ready", i), if_ready, vecs[i].e_ifr);
            chk($sformatf("vec%0d_d_ready", i), d_ready, vecs[i].e_dr);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_we);
            chk($sformatf("vec%0d_if_valid", i), if_valid, vecs[i].e_ifv);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].e_ifd);
            chk($sformatf("vec%0d_d_valid", i), d_valid, vecs[i].e_dv);
            chk($sformatf("vec%0d_d_rdata", i), d_rdata, vecs[i].e_dd);
            finish_cycle();
        end

        // Asynchronous reset while a load is in flight and the streak is part-way up.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, 0, 32'h40, 0, 0);
            half_check();
            finish_cycle();
        end
        drive(1, 0, 0, 1, 0, 32'h40, 0, 0);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_async_d_valid", d_valid, 0);
        chk("rst_async_d_rdata", d_rdata, 0);
        chk("rst_async_if_valid", if_valid, 0);
        half_check();
        finish_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        half_check();
        finish_cycle();
        rst = 1'b0;
        half_check();
        chk("rst_release_d_valid", d_valid, 0);
        finish_cycle();

        d_before_if = 0;
        seen_if = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 1, 0, 32'h40, 0, 0);
            half_check();
            if (!seen_if) begin
                if (if_ready) seen_if = 1;
                else if (d_ready) d_before_if++;
            end
            finish_cycle();
        end
        chk("rst_streak_cleared", d_before_if, MAXS);
        chk("rst_streak_if_seen", seen_if, 1);

        // Randomized traffic obeying the hold-until-ready protocol.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        half_check();
        finish_cycle();
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || exp_gi) begin
                if_req  = ($urandom % 3) != 0;
                if_addr = 32'($urandom_range(0, 255));
            end
            if_flush = ($urandom % 4) == 0;
            if (!d_req || exp_gd) begin
                d_req   = ($urandom % 2) != 0;
                d_we    = ($urandom % 2) != 0;
                d_addr  = 32'($urandom_range(0, 255));
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            half_check();
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
